// File: rtl/dimm_pkg.sv
// rtl/dimm_pkg.sv - shared command, violation and bank-state encodings for the DIMM tracker
//
// Purpose: common typedefs used by dimm_cmd_tracker and bank_timer.
// Ports:   none (package).

package dimm_pkg;

  // Decoded DDR4 command, as reported on cmd_code.
  typedef enum logic [3:0] {
    CMD_NOP  = 4'd0,
    CMD_ACT  = 4'd1,
    CMD_RD   = 4'd2,
    CMD_RDA  = 4'd3,
    CMD_WR   = 4'd4,
    CMD_WRA  = 4'd5,
    CMD_PRE  = 4'd6,
    CMD_PREA = 4'd7,
    CMD_REF  = 4'd8,
    CMD_SRE  = 4'd9,
    CMD_MRS  = 4'd10
  } cmd_e;

  // Timing / protocol violation, as reported on viol_code.
  typedef enum logic [2:0] {
    VIOL_NONE     = 3'd0,
    VIOL_MULTI_CS = 3'd1,
    VIOL_ACT_BUSY = 3'd2,
    VIOL_NOT_OPEN = 3'd3,
    VIOL_TRCD     = 3'd4,
    VIOL_TRAS     = 3'd5,
    VIOL_REF_BUSY = 3'd6
  } viol_e;

  typedef enum logic [1:0] {
    BS_IDLE        = 2'd0,
    BS_ACTIVATING  = 2'd1,
    BS_ACTIVE      = 2'd2,
    BS_PRECHARGING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/bank_timer.sv
// rtl/bank_timer.sv - one bank's state machine with tRCD/tRAS/tRP counters
//
// Purpose: tracks IDLE/ACTIVATING/ACTIVE/PRECHARGING for a single rank x bank.
// Ports:
//   ck_t, reset_n   command clock, async active-low reset
//   cmd             decoded command of this cycle
//   hit             command addresses this bank on the selected rank
//   rank_hit        this bank's rank is the (single) selected rank
//   commit          command is legal and takes effect
//   eff_state       state as seen by a command on this edge
//   ras_busy        tRAS still running
//   is_open         registered state is ACTIVE

module bank_timer
  import dimm_pkg::*;
#(
  parameter int TRCD = 16,
  parameter int TRP  = 16,
  parameter int TRAS = 39,
  parameter int CNTW = 8
) (
  input  logic        ck_t,
  input  logic        reset_n,
  input  cmd_e        cmd,
  input  logic        hit,
  input  logic        rank_hit,
  input  logic        commit,
  output bank_state_e eff_state,
  output logic        ras_busy,
  output logic        is_open
);

  bank_state_e     state;
  logic [CNTW-1:0] rcd;
  logic [CNTW-1:0] ras;
  logic [CNTW-1:0] rp;
  logic            do_act;
  logic            do_pre;

  // A timed state whose counter has already expired behaves as its successor,
  // so a command on the very edge the FSM advances is judged by that successor.
  always_comb begin
    eff_state = state;
    if (state == BS_ACTIVATING && rcd == '0)
      eff_state = BS_ACTIVE;
    else if (state == BS_PRECHARGING && rp == '0)
      eff_state = BS_IDLE;
  end

  assign ras_busy = (ras != '0);
  assign is_open  = (state == BS_ACTIVE);

  assign do_act = commit && hit && (cmd == CMD_ACT) && (eff_state == BS_IDLE);

  // PRE to an idle/precharging bank is a legal no-op, hence the ACTIVE guard.
  assign do_pre = commit && (eff_state == BS_ACTIVE) &&
                  ((hit && (cmd == CMD_PRE || cmd == CMD_RDA || cmd == CMD_WRA)) ||
                   (rank_hit && cmd == CMD_PREA));

  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      state <= BS_IDLE;
      rcd   <= '0;
      ras   <= '0;
      rp    <= '0;
    end else begin
      state <= eff_state;
      rcd   <= (rcd != '0) ? rcd - CNTW'(1) : '0;
      ras   <= (ras != '0) ? ras - CNTW'(1) : '0;
      rp    <= (rp  != '0) ? rp  - CNTW'(1) : '0;
      if (do_act) begin
        state <= BS_ACTIVATING;
        rcd   <= CNTW'(TRCD - 1);
        ras   <= CNTW'(TRAS - 1);
      end
      if (do_pre) begin
        state <= BS_PRECHARGING;
        rp    <= CNTW'(TRP - 1);
      end
    end
  end

endmodule

// File: rtl/dimm_cmd_tracker.sv
// rtl/dimm_cmd_tracker.sv - registered DDR4 command decode with per-bank timing checks
//
// Purpose: decodes one command per ck_t edge, tracks every rank x bank FSM and
//          reports the command plus any timing/protocol violation.
// Ports:
//   ck_t, reset_n          command clock, async active-low reset
//   cke, cs_n, act_n, A    DDR4 command pins (A16..A14 = RAS_n/CAS_n/WE_n, A10 = AP)
//   bg, ba                 bank group / bank
//   cmd_valid..cmd_col     registered decoded command (one-cycle)
//   viol, viol_code        registered violation pulse and cause
//   bank_open              per rank x bank ACTIVE flags, index rank*BANKS+bank

module dimm_cmd_tracker
  import dimm_pkg::*;
#(
  parameter int ADDRWIDTH     = 17,
  parameter int RANKS         = 2,
  parameter int BANKGROUPS    = 4,
  parameter int BANKSPERGROUP = 4,
  parameter int COLS          = 1024,
  parameter int TRCD          = 16,
  parameter int TRP           = 16,
  parameter int TRAS          = 39,
  parameter int CNTW          = 8
) (
  input  logic                                         ck_t,
  input  logic                                         reset_n,
  input  logic                                         cke,
  input  logic [RANKS-1:0]                             cs_n,
  input  logic                                         act_n,
  input  logic [ADDRWIDTH-1:0]                         A,
  input  logic [$clog2(BANKGROUPS)-1:0]                bg,
  input  logic [$clog2(BANKSPERGROUP)-1:0]             ba,
  output logic                                         cmd_valid,
  output logic [3:0]                                   cmd_code,
  output logic [$clog2(RANKS)-1:0]                     cmd_rank,
  output logic [$clog2(BANKGROUPS*BANKSPERGROUP)-1:0]  cmd_bank,
  output logic [ADDRWIDTH-1:0]                         cmd_row,
  output logic [$clog2(COLS)-1:0]                      cmd_col,
  output logic                                         viol,
  output logic [2:0]                                   viol_code,
  output logic [RANKS*BANKGROUPS*BANKSPERGROUP-1:0]    bank_open
);

  localparam int BANKS = BANKGROUPS * BANKSPERGROUP;
  localparam int NB    = RANKS * BANKS;
  localparam int RW    = $clog2(RANKS);
  localparam int BW    = $clog2(BANKS);
  localparam int CW    = $clog2(COLS);

  logic          single;
  logic          multi;
  logic [RW-1:0] sel_rank;
  logic [BW-1:0] flat_bank;
  logic [2:0]    op;
  cmd_e          dec_cmd;
  viol_e         vcode;
  logic          commit;

  bank_state_e   st [NB];
  logic [NB-1:0] ras_busy;
  logic [NB-1:0] hit;
  logic [NB-1:0] rank_hit;
  logic [NB-1:0] is_open;

  bank_state_e   tgt_st;
  logic          tgt_ras;
  logic          rank_ras;
  logic          rank_busy;

  assign single    = $onehot(~cs_n);
  assign multi     = !single && !(&cs_n);
  assign flat_bank = BW'(bg) * BW'(BANKSPERGROUP) + BW'(ba);
  assign op        = A[ADDRWIDTH-1 -: 3];

  always_comb begin
    sel_rank = '0;
    for (int r = 0; r < RANKS; r++)
      if (!cs_n[r]) sel_rank = RW'(r);
  end

  always_comb begin
    dec_cmd = CMD_NOP;
    if (!act_n) begin
      dec_cmd = CMD_ACT;
    end else begin
      case (op)
        3'b101:  dec_cmd = A[10] ? CMD_RDA  : CMD_RD;
        3'b100:  dec_cmd = A[10] ? CMD_WRA  : CMD_WR;
        3'b010:  dec_cmd = A[10] ? CMD_PREA : CMD_PRE;
        3'b001:  dec_cmd = cke   ? CMD_REF  : CMD_SRE;
        3'b000:  dec_cmd = CMD_MRS;
        default: dec_cmd = CMD_NOP;
      endcase
    end
  end

  for (genvar r = 0; r < RANKS; r++) begin : g_rank
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      localparam int I = r * BANKS + b;

      assign rank_hit[I] = single && (sel_rank == RW'(r));
      assign hit[I]      = rank_hit[I] && (flat_bank == BW'(b));

      bank_timer #(
        .TRCD (TRCD),
        .TRP  (TRP),
        .TRAS (TRAS),
        .CNTW (CNTW)
      ) u_timer (
        .ck_t      (ck_t),
        .reset_n   (reset_n),
        .cmd       (dec_cmd),
        .hit       (hit[I]),
        .rank_hit  (rank_hit[I]),
        .commit    (commit),
        .eff_state (st[I]),
        .ras_busy  (ras_busy[I]),
        .is_open   (is_open[I])
      );
    end
  end

  // Gather the addressed bank and the selected rank's aggregate status.
  always_comb begin
    tgt_st    = BS_IDLE;
    tgt_ras   = 1'b0;
    rank_ras  = 1'b0;
    rank_busy = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (hit[i]) begin
        tgt_st  = st[i];
        tgt_ras = ras_busy[i];
      end
      if (rank_hit[i]) begin
        rank_ras = rank_ras | ras_busy[i];
        if (st[i] != BS_IDLE) rank_busy = 1'b1;
      end
    end
  end

  always_comb begin
    vcode = VIOL_NONE;
    case (dec_cmd)
      CMD_ACT:
        if (tgt_st != BS_IDLE) vcode = VIOL_ACT_BUSY;
      CMD_RD, CMD_WR, CMD_RDA, CMD_WRA:
        if (tgt_st == BS_ACTIVATING)
          vcode = VIOL_TRCD;
        else if (tgt_st != BS_ACTIVE)
          vcode = VIOL_NOT_OPEN;
        else if ((dec_cmd == CMD_RDA || dec_cmd == CMD_WRA) && tgt_ras)
          vcode = VIOL_TRAS;
      CMD_PRE:
        if (tgt_ras) vcode = VIOL_TRAS;
      CMD_PREA:
        if (rank_ras) vcode = VIOL_TRAS;
      CMD_REF, CMD_SRE, CMD_MRS:
        if (rank_busy) vcode = VIOL_REF_BUSY;
      default: vcode = VIOL_NONE;
    endcase
  end

  // Any violation freezes every bank FSM for this edge.
  assign commit = single && (vcode == VIOL_NONE);

  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NOP;
      cmd_rank  <= '0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      viol      <= 1'b0;
      viol_code <= VIOL_NONE;
    end else begin
      cmd_valid <= single && (dec_cmd != CMD_NOP);
      viol      <= multi || (single && vcode != VIOL_NONE);
      if (single && dec_cmd != CMD_NOP) begin
        cmd_code  <= dec_cmd;
        cmd_rank  <= sel_rank;
        cmd_bank  <= flat_bank;
        cmd_row   <= A;
        cmd_col   <= A[CW-1:0];
        viol_code <= vcode;
      end else begin
        cmd_code  <= CMD_NOP;
        cmd_rank  <= '0;
        cmd_bank  <= '0;
        cmd_row   <= '0;
        cmd_col   <= '0;
        viol_code <= multi ? VIOL_MULTI_CS : VIOL_NONE;
      end
    end
  end

  assign bank_open = is_open;

endmodule
